// File: rtl/bomb_manager.sv
// Shared pool of bomb slots: placement arbitration, fuse/blast countdowns and blast-cross decode.
// Optional macro BOMB_CHAIN_EN: a fusing bomb caught in a blast detonates on the next clock edge.
module bomb_manager #(
    parameter int unsigned HTILES      = 10,
    parameter int unsigned VTILES      = 6,
    parameter int unsigned SLOTS       = 4,
    parameter int unsigned TICK_DIV    = 25000000,
    parameter int unsigned FUSE_TICKS  = 3,
    parameter int unsigned BLAST_TICKS = 1,
    parameter int unsigned RADIUS      = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       placeA,
    input  logic                       placeB,
    input  logic [3:0]                 curAh,
    input  logic [3:0]                 curAv,
    input  logic [3:0]                 curBh,
    input  logic [3:0]                 curBv,
    input  logic [HTILES*VTILES-1:0]   walkAble,
    output logic [HTILES*VTILES-1:0]   bombMap,
    output logic [HTILES*VTILES-1:0]   blastMap,
    output logic                       hitA,
    output logic                       hitB,
    output logic [2:0]                 freeSlots,
    output logic                       reject
);

    localparam int unsigned NTILES = HTILES * VTILES;
    localparam int unsigned TW     = $clog2(NTILES);
    localparam int unsigned DW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned MAXT   = (FUSE_TICKS > BLAST_TICKS) ? FUSE_TICKS : BLAST_TICKS;
    localparam int unsigned CW     = $clog2(MAXT + 1);

    typedef enum logic [1:0] {StIdle, StFuse, StBlast} slot_state_e;

    function automatic logic [NTILES-1:0] col_mask(input int unsigned col);
        logic [NTILES-1:0] m;
        m = '0;
        for (int unsigned t = 0; t < NTILES; t++) m[t] = ((t % HTILES) == col);
        return m;
    endfunction

    function automatic logic [NTILES-1:0] tile_hot(input logic [TW-1:0] idx);
        logic [NTILES-1:0] h;
        h    = '0;
        h[0] = 1'b1;
        return h << idx;
    endfunction

    localparam logic [NTILES-1:0] FirstCol = col_mask(0);
    localparam logic [NTILES-1:0] LastCol  = col_mask(HTILES - 1);

    slot_state_e       state_q [SLOTS];
    slot_state_e       state_d [SLOTS];
    logic [TW-1:0]     tile_q  [SLOTS];
    logic [TW-1:0]     tile_d  [SLOTS];
    logic [CW-1:0]     cnt_q   [SLOTS];
    logic [CW-1:0]     cnt_d   [SLOTS];
    logic [DW-1:0]     tick_cnt_q, tick_cnt_d;
    logic              reject_q, reject_d;
    logic              tick;

    logic              a_in, b_in, a_ok, b_ok;
    logic [TW-1:0]     a_idx, b_idx;
    logic [NTILES-1:0] a_hot, b_hot, occupied;
    logic [SLOTS-1:0]  a_sel, b_sel;
    logic [NTILES-1:0] arm_e, arm_w, arm_n, arm_s;
    logic [2:0]        free_cnt;

    assign tick       = (tick_cnt_q == DW'(TICK_DIV - 1));
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + DW'(1);

    // Fuse decode and blast crosses; arms shift one tile per step and die on walls or edges.
    always_comb begin
        bombMap  = '0;
        blastMap = '0;
        arm_e    = '0;
        arm_w    = '0;
        arm_n    = '0;
        arm_s    = '0;
        for (int unsigned s = 0; s < SLOTS; s++) begin
            if (state_q[s] == StFuse) bombMap |= tile_hot(tile_q[s]);
            if (state_q[s] == StBlast) begin
                arm_e = tile_hot(tile_q[s]);
                arm_w = arm_e;
                arm_n = arm_e;
                arm_s = arm_e;
                blastMap |= arm_e;
                for (int unsigned r = 0; r < RADIUS; r++) begin
                    arm_e = (arm_e << 1) & ~FirstCol & walkAble;
                    arm_w = (arm_w >> 1) & ~LastCol & walkAble;
                    arm_s = (arm_s << HTILES) & walkAble;
                    arm_n = (arm_n >> HTILES) & walkAble;
                    blastMap |= arm_e | arm_w | arm_s | arm_n;
                end
            end
        end
    end

    always_comb begin
        a_in  = (32'(curAh) < HTILES) && (32'(curAv) < VTILES);
        b_in  = (32'(curBh) < HTILES) && (32'(curBv) < VTILES);
        a_idx = TW'(32'(curAv) * HTILES + 32'(curAh));
        b_idx = TW'(32'(curBv) * HTILES + 32'(curBh));
        a_hot = a_in ? tile_hot(a_idx) : '0;
        b_hot = b_in ? tile_hot(b_idx) : '0;
        hitA  = |(blastMap & a_hot);
        hitB  = |(blastMap & b_hot);
    end

    // A is arbitrated first; B sees the pool minus whatever A claims this cycle.
    always_comb begin
        occupied = bombMap | blastMap;
        a_sel    = '0;
        b_sel    = '0;
        for (int unsigned s = 0; s < SLOTS; s++) begin
            if (state_q[s] == StIdle && a_sel == '0) a_sel[s] = 1'b1;
        end
        a_ok = placeA && a_in && ((occupied & a_hot) == '0) && (a_sel != '0);
        for (int unsigned s = 0; s < SLOTS; s++) begin
            if (state_q[s] == StIdle && !(a_ok && a_sel[s]) && b_sel == '0) b_sel[s] = 1'b1;
        end
        b_ok = placeB && b_in && ((occupied & b_hot) == '0) && (b_sel != '0)
               && !(a_ok && (a_hot == b_hot));
        reject_d = (placeA && !a_ok) || (placeB && !b_ok);
    end

    always_comb begin
        free_cnt = '0;
        for (int unsigned s = 0; s < SLOTS; s++) begin
            if (state_q[s] == StIdle) free_cnt = free_cnt + 3'd1;
        end
        freeSlots = free_cnt;
        reject    = reject_q;
    end

    always_comb begin
        for (int unsigned s = 0; s < SLOTS; s++) begin
            state_d[s] = state_q[s];
            tile_d[s]  = tile_q[s];
            cnt_d[s]   = cnt_q[s];
            unique case (state_q[s])
                StIdle: begin
                    if (a_ok && a_sel[s]) begin
                        state_d[s] = StFuse;
                        tile_d[s]  = a_idx;
                        cnt_d[s]   = CW'(FUSE_TICKS);
                    end else if (b_ok && b_sel[s]) begin
                        state_d[s] = StFuse;
                        tile_d[s]  = b_idx;
                        cnt_d[s]   = CW'(FUSE_TICKS);
                    end
                end
                StFuse: begin
`ifdef BOMB_CHAIN_EN
                    if (|(blastMap & tile_hot(tile_q[s]))) begin
                        state_d[s] = StBlast;
                        cnt_d[s]   = CW'(BLAST_TICKS);
                    end else if (tick) begin
`else
                    if (tick) begin
`endif
                        if (cnt_q[s] == CW'(1)) begin
                            state_d[s] = StBlast;
                            cnt_d[s]   = CW'(BLAST_TICKS);
                        end else begin
                            cnt_d[s] = cnt_q[s] - CW'(1);
                        end
                    end
                end
                StBlast: begin
                    if (tick) begin
                        if (cnt_q[s] == CW'(1)) state_d[s] = StIdle;
                        else                    cnt_d[s]   = cnt_q[s] - CW'(1);
                    end
                end
                default: state_d[s] = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt_q <= '0;
            reject_q   <= 1'b0;
            for (int unsigned s = 0; s < SLOTS; s++) begin
                state_q[s] <= StIdle;
                tile_q[s]  <= '0;
                cnt_q[s]   <= '0;
            end
        end else begin
            tick_cnt_q <= tick_cnt_d;
            reject_q   <= reject_d;
            for (int unsigned s = 0; s < SLOTS; s++) begin
                state_q[s] <= state_d[s];
                tile_q[s]  <= tile_d[s];
                cnt_q[s]   <= cnt_d[s];
            end
        end
    end

endmodule
